// File: rtl/alu_uart_if_if.sv
// alu_uart_if_if: UART byte stream and ALU operand/result bus bundle for alu_uart_if
interface alu_uart_if_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] i_resultado;
  logic [DATA_WIDTH-1:0] o_dato_A;
  logic [DATA_WIDTH-1:0] o_dato_B;
  logic [OP_WIDTH-1:0]   o_op;
  logic [7:0]            o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_resultado,
    output o_dato_A, o_dato_B, o_op, o_tx_data, o_tx_start, o_busy
  );
  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_resultado,
    input  o_dato_A, o_dato_B, o_op, o_tx_data, o_tx_start, o_busy
  );
endinterface

// File: rtl/alu_uart_if.sv
// alu_uart_if: collects A, B and op bytes from a UART, feeds an ALU and streams the result back; ALU_UART_IF_OP_CHECK_EN enables op-code validation
module alu_uart_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_uart_if_if.slave  bus
);
  localparam int N = DATA_WIDTH / 8;
  localparam logic [1:0] LAST = 2'(N - 1);
  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, WAIT_ALU, TX_SEND, TX_WAIT} state_t;
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dato_a_q, dato_a_d;
  logic [DATA_WIDTH-1:0] dato_b_q, dato_b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  op_ok;
  logic                  last;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] byte_in;
`ifdef ALU_UART_IF_OP_CHECK_EN
  logic [7:0] op_code;
  assign op_code = 8'(bus.i_rx_data[OP_WIDTH-1:0]);
  assign op_ok   = op_code inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
`else
  assign op_ok = 1'b1;
`endif
  // one counter serves both operand byte position and result byte position
  assign last      = cnt_q == LAST;
  assign sh        = {cnt_q, 3'b000};
  assign byte_mask = DATA_WIDTH'(8'hFF) << sh;
  assign byte_in   = DATA_WIDTH'(bus.i_rx_data) << sh;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RX_A;
    else          state_q <= state_d;
  end
  // next-state logic; an invalid op skips the ALU and goes straight to sending
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A:     if (bus.i_rx_done && last) state_d = RX_B;
      RX_B:     if (bus.i_rx_done && last) state_d = RX_OP;
      RX_OP:    if (bus.i_rx_done) state_d = op_ok ? WAIT_ALU : TX_SEND;
      WAIT_ALU: state_d = TX_SEND;
      TX_SEND:  state_d = TX_WAIT;
      TX_WAIT:  if (bus.i_tx_done) state_d = last ? RX_A : TX_SEND;
      default:  state_d = RX_A;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    bus.o_busy     = state_q inside {WAIT_ALU, TX_SEND, TX_WAIT};
    bus.o_tx_start = state_q == TX_SEND;
  end
  // datapath next values; the error byte presets the counter so only one byte goes out
  always_comb begin
    cnt_d     = cnt_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    res_d     = res_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    case (state_q)
      RX_A: if (bus.i_rx_done) begin
        dato_a_d = (dato_a_q & ~byte_mask) | byte_in;
        cnt_d    = last ? 2'd0 : cnt_q + 2'd1;
      end
      RX_B: if (bus.i_rx_done) begin
        dato_b_d = (dato_b_q & ~byte_mask) | byte_in;
        cnt_d    = last ? 2'd0 : cnt_q + 2'd1;
      end
      RX_OP: if (bus.i_rx_done) begin
        op_d      = op_ok ? bus.i_rx_data[OP_WIDTH-1:0] : op_q;
        tx_data_d = op_ok ? tx_data_q : 8'hEE;
        cnt_d     = op_ok ? 2'd0 : LAST;
      end
      WAIT_ALU: begin
        res_d     = bus.i_resultado;
        tx_data_d = bus.i_resultado[7:0];
        cnt_d     = 2'd0;
      end
      TX_WAIT: if (bus.i_tx_done) begin
        cnt_d     = last ? 2'd0 : cnt_q + 2'd1;
        tx_data_d = last ? tx_data_q : 8'(res_q >> {cnt_q + 2'd1, 3'b000});
      end
      default: ;
    endcase
  end
  // datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      res_q     <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      res_q     <= res_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
    end
  end
  assign bus.o_dato_A  = dato_a_q;
  assign bus.o_dato_B  = dato_b_q;
  assign bus.o_op      = op_q;
  assign bus.o_tx_data = tx_data_q;
endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: directed checks of alu_uart_if at 8-bit and 16-bit data widths
module tb_alu_uart_if;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  int starts8 = 0;
  int starts16 = 0;
  alu_uart_if_if #(.DATA_WIDTH(8),  .OP_WIDTH(6)) b8();
  alu_uart_if_if #(.DATA_WIDTH(16), .OP_WIDTH(6)) b16();
  alu_uart_if #(.DATA_WIDTH(8),  .OP_WIDTH(6)) dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
  alu_uart_if #(.DATA_WIDTH(16), .OP_WIDTH(6)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(b16));
  always #5 clk = ~clk;
  always_comb begin
    case (b8.o_op)
      6'h20:   b8.i_resultado = b8.o_dato_A + b8.o_dato_B;
      6'h22:   b8.i_resultado = b8.o_dato_A - b8.o_dato_B;
      6'h24:   b8.i_resultado = b8.o_dato_A & b8.o_dato_B;
      6'h25:   b8.i_resultado = b8.o_dato_A | b8.o_dato_B;
      6'h26:   b8.i_resultado = b8.o_dato_A ^ b8.o_dato_B;
      6'h27:   b8.i_resultado = ~(b8.o_dato_A | b8.o_dato_B);
      6'h02:   b8.i_resultado = b8.o_dato_A >> b8.o_dato_B;
      6'h03:   b8.i_resultado = $signed(b8.o_dato_A) >>> b8.o_dato_B;
      default: b8.i_resultado = 8'h00;
    endcase
  end
  always_comb begin
    case (b16.o_op)
      6'h20:   b16.i_resultado = b16.o_dato_A + b16.o_dato_B;
      6'h22:   b16.i_resultado = b16.o_dato_A - b16.o_dato_B;
      default: b16.i_resultado = 16'h0000;
    endcase
  end
  always @(posedge clk) begin
    if (b8.o_tx_start) starts8++;
    if (b16.o_tx_start) starts16++;
  end
  task automatic rx8(input logic [7:0] d);
    @(negedge clk); b8.i_rx_data = d; b8.i_rx_done = 1'b1;
    @(negedge clk); b8.i_rx_done = 1'b0;
  endtask
  task automatic tx8;
    @(negedge clk); b8.i_tx_done = 1'b1;
    @(negedge clk); b8.i_tx_done = 1'b0;
  endtask
  task automatic rx16(input logic [7:0] d);
    @(negedge clk); b16.i_rx_data = d; b16.i_rx_done = 1'b1;
    @(negedge clk); b16.i_rx_done = 1'b0;
  endtask
  task automatic tx16;
    @(negedge clk); b16.i_tx_done = 1'b1;
    @(negedge clk); b16.i_tx_done = 1'b0;
  endtask
  task automatic frame8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rx8(a); rx8(b); rx8(op);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (b8.o_dato_A !== 8'h00) begin fails++; $display("FAIL reset_A got %h want 00", b8.o_dato_A); end
    checks++; if (b8.o_dato_B !== 8'h00) begin fails++; $display("FAIL reset_B got %h want 00", b8.o_dato_B); end
    checks++; if (b8.o_op !== 6'h00) begin fails++; $display("FAIL reset_op got %h want 00", b8.o_op); end
    checks++; if (b8.o_tx_data !== 8'h00) begin fails++; $display("FAIL reset_txdata got %h want 00", b8.o_tx_data); end
    checks++; if (b8.o_tx_start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", b8.o_tx_start); end
    checks++; if (b8.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b8.o_busy); end
    checks++; if (b16.o_dato_A !== 16'h0000) begin fails++; $display("FAIL reset_A16 got %h want 0000", b16.o_dato_A); end
    rst_n = 1'b1;
  endtask
  task automatic test_add;
    int s;
    s = starts8;
    frame8(8'h10, 8'h02, 8'h20);
    checks++; if (b8.o_op !== 6'h20) begin fails++; $display("FAIL add_op got %h want 20", b8.o_op); end
    checks++; if (b8.o_dato_A !== 8'h10) begin fails++; $display("FAIL add_A got %h want 10", b8.o_dato_A); end
    checks++; if (b8.o_dato_B !== 8'h02) begin fails++; $display("FAIL add_B got %h want 02", b8.o_dato_B); end
    checks++; if (b8.o_tx_start !== 1'b0) begin fails++; $display("FAIL add_start_early got %b want 0", b8.o_tx_start); end
    checks++; if (b8.o_busy !== 1'b1) begin fails++; $display("FAIL add_busy_wait got %b want 1", b8.o_busy); end
    @(negedge clk);
    checks++; if (b8.o_tx_start !== 1'b1) begin fails++; $display("FAIL add_start got %b want 1", b8.o_tx_start); end
    checks++; if (b8.o_tx_data !== 8'h12) begin fails++; $display("FAIL add_txdata got %h want 12", b8.o_tx_data); end
    @(negedge clk);
    checks++; if (b8.o_tx_start !== 1'b0) begin fails++; $display("FAIL add_start_pulse got %b want 0", b8.o_tx_start); end
    checks++; if (b8.o_busy !== 1'b1) begin fails++; $display("FAIL add_busy_txwait got %b want 1", b8.o_busy); end
    tx8;
    checks++; if (b8.o_busy !== 1'b0) begin fails++; $display("FAIL add_busy_done got %b want 0", b8.o_busy); end
    checks++; if (starts8 - s !== 1) begin fails++; $display("FAIL add_start_count got %0d want 1", starts8 - s); end
  endtask
  task automatic test_ops;
    frame8(8'h90, 8'h02, 8'h03);
    @(negedge clk);
    checks++; if (b8.o_tx_data !== 8'hE4) begin fails++; $display("FAIL sra_txdata got %h want e4", b8.o_tx_data); end
    tx8;
    frame8(8'h10, 8'h02, 8'h22);
    @(negedge clk);
    checks++; if (b8.o_tx_data !== 8'h0E) begin fails++; $display("FAIL sub_txdata got %h want 0e", b8.o_tx_data); end
    tx8;
  endtask
  task automatic test_tx_ignore;
    int s;
    s = starts8;
    tx8;
    repeat (2) @(negedge clk);
    checks++; if (b8.o_busy !== 1'b0) begin fails++; $display("FAIL txign_busy got %b want 0", b8.o_busy); end
    checks++; if (starts8 - s !== 0) begin fails++; $display("FAIL txign_starts got %0d want 0", starts8 - s); end
  endtask
  task automatic test_wide;
    int s;
    s = starts16;
    rx16(8'h10);
    checks++; if (b16.o_dato_A !== 16'h0010) begin fails++; $display("FAIL wide_A_partial got %h want 0010", b16.o_dato_A); end
    rx16(8'h00);
    checks++; if (b16.o_busy !== 1'b0) begin fails++; $display("FAIL wide_busy_rx got %b want 0", b16.o_busy); end
    rx16(8'h02);
    checks++; if (b16.o_dato_B !== 16'h0002) begin fails++; $display("FAIL wide_B_partial got %h want 0002", b16.o_dato_B); end
    rx16(8'h00);
    rx16(8'h20);
    checks++; if (b16.o_dato_A !== 16'h0010) begin fails++; $display("FAIL wide_A got %h want 0010", b16.o_dato_A); end
    checks++; if (b16.o_dato_B !== 16'h0002) begin fails++; $display("FAIL wide_B got %h want 0002", b16.o_dato_B); end
    checks++; if (b16.o_op !== 6'h20) begin fails++; $display("FAIL wide_op got %h want 20", b16.o_op); end
    @(negedge clk);
    checks++; if (b16.o_tx_start !== 1'b1) begin fails++; $display("FAIL wide_start0 got %b want 1", b16.o_tx_start); end
    checks++; if (b16.o_tx_data !== 8'h12) begin fails++; $display("FAIL wide_byte0 got %h want 12", b16.o_tx_data); end
    repeat (4) @(negedge clk);
    checks++; if (starts16 - s !== 1) begin fails++; $display("FAIL wide_hold_starts got %0d want 1", starts16 - s); end
    checks++; if (b16.o_busy !== 1'b1) begin fails++; $display("FAIL wide_hold_busy got %b want 1", b16.o_busy); end
    tx16;
    checks++; if (b16.o_tx_start !== 1'b1) begin fails++; $display("FAIL wide_start1 got %b want 1", b16.o_tx_start); end
    checks++; if (b16.o_tx_data !== 8'h00) begin fails++; $display("FAIL wide_byte1 got %h want 00", b16.o_tx_data); end
    @(negedge clk);
    tx16;
    checks++; if (b16.o_busy !== 1'b0) begin fails++; $display("FAIL wide_busy_done got %b want 0", b16.o_busy); end
    checks++; if (starts16 - s !== 2) begin fails++; $display("FAIL wide_starts got %0d want 2", starts16 - s); end
  endtask
  task automatic test_drop;
    frame8(8'h10, 8'h02, 8'h20);
    repeat (2) @(negedge clk);
    rx8(8'h55);
    checks++; if (b8.o_dato_A !== 8'h10) begin fails++; $display("FAIL drop_A got %h want 10", b8.o_dato_A); end
    checks++; if (b8.o_busy !== 1'b1) begin fails++; $display("FAIL drop_busy got %b want 1", b8.o_busy); end
    tx8;
    frame8(8'h01, 8'h01, 8'h20);
    @(negedge clk);
    checks++; if (b8.o_tx_start !== 1'b1) begin fails++; $display("FAIL drop_next_start got %b want 1", b8.o_tx_start); end
    checks++; if (b8.o_tx_data !== 8'h02) begin fails++; $display("FAIL drop_next_txdata got %h want 02", b8.o_tx_data); end
    tx8;
  endtask
  task automatic test_reset_abort;
    int s;
    s = starts8;
    rx8(8'h07);
    rx8(8'h09);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (b8.o_dato_A !== 8'h00) begin fails++; $display("FAIL abort_async_A got %h want 00", b8.o_dato_A); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (starts8 - s !== 0) begin fails++; $display("FAIL abort_no_tx got %0d want 0", starts8 - s); end
    frame8(8'h03, 8'h04, 8'h24);
    checks++; if (b8.o_op !== 6'h24) begin fails++; $display("FAIL abort_op got %h want 24", b8.o_op); end
    @(negedge clk);
    checks++; if (b8.o_tx_data !== 8'h00) begin fails++; $display("FAIL abort_txdata got %h want 00", b8.o_tx_data); end
    tx8;
    repeat (3) @(negedge clk);
    checks++; if (starts8 - s !== 1) begin fails++; $display("FAIL abort_one_tx got %0d want 1", starts8 - s); end
    s = starts8;
    frame8(8'h05, 8'h05, 8'h20);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (b8.o_busy !== 1'b0) begin fails++; $display("FAIL abort_tx_busy got %b want 0", b8.o_busy); end
    checks++; if (b8.o_tx_data !== 8'h00) begin fails++; $display("FAIL abort_tx_txdata got %h want 00", b8.o_tx_data); end
    @(negedge clk); rst_n = 1'b1;
    tx8;
    repeat (4) @(negedge clk);
    checks++; if (starts8 - s !== 1) begin fails++; $display("FAIL abort_tx_starts got %0d want 1", starts8 - s); end
  endtask
  task automatic test_op_check;
    frame8(8'h05, 8'h03, 8'h20);
    @(negedge clk);
    checks++; if (b8.o_tx_data !== 8'h08) begin fails++; $display("FAIL opchk_valid got %h want 08", b8.o_tx_data); end
    tx8;
    frame8(8'h05, 8'h03, 8'h3F);
`ifdef ALU_UART_IF_OP_CHECK_EN
    checks++; if (b8.o_op !== 6'h20) begin fails++; $display("FAIL opchk_op got %h want 20", b8.o_op); end
    checks++; if (b8.o_tx_start !== 1'b1) begin fails++; $display("FAIL opchk_start got %b want 1", b8.o_tx_start); end
    checks++; if (b8.o_tx_data !== 8'hEE) begin fails++; $display("FAIL opchk_err got %h want ee", b8.o_tx_data); end
`else
    checks++; if (b8.o_op !== 6'h3F) begin fails++; $display("FAIL opchk_op got %h want 3f", b8.o_op); end
    checks++; if (b8.o_tx_start !== 1'b0) begin fails++; $display("FAIL opchk_start_early got %b want 0", b8.o_tx_start); end
    @(negedge clk);
    checks++; if (b8.o_tx_data !== 8'h00) begin fails++; $display("FAIL opchk_result got %h want 00", b8.o_tx_data); end
`endif
    @(negedge clk);
    tx8;
    checks++; if (b8.o_busy !== 1'b0) begin fails++; $display("FAIL opchk_busy got %b want 0", b8.o_busy); end
  endtask
  initial begin
    b8.i_rx_data = 8'h00; b8.i_rx_done = 1'b0; b8.i_tx_done = 1'b0;
    b16.i_rx_data = 8'h00; b16.i_rx_done = 1'b0; b16.i_tx_done = 1'b0;
    test_reset;
    test_add;
    test_ops;
    test_tx_ignore;
    test_wide;
    test_drop;
    test_reset_abort;
    test_op_check;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the ALU operand/result width; legal values 8, 16, 24 or 32.
REQ-002 The block SHALL have parameter OP_WIDTH, default 6, meaning the ALU operation code width.
REQ-003 i_clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rx_data  input  8  received byte from the UART receiver.
REQ-006 i_rx_done  input  1  one-cycle pulse; i_rx_data valid in that cycle.
REQ-007 i_tx_done  input  1  one-cycle pulse from the UART transmitter; previous byte fully sent.
REQ-008 i_resultado  input  DATA_WIDTH  combinational ALU result.
REQ-009 o_dato_A  output  DATA_WIDTH  operand A to the ALU, registered.
REQ-010 o_dato_B  output  DATA_WIDTH  operand B to the ALU, registered.
REQ-011 o_op  output  OP_WIDTH  operation code to the ALU, registered.
REQ-012 o_tx_data  output  8  byte to transmit, registered.
REQ-013 o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-014 o_busy  output  1  high while in WAIT_ALU, TX_SEND or TX_WAIT.

Function
REQ-015 The FSM SHALL have states RX_A, RX_B, RX_OP, WAIT_ALU, TX_SEND, TX_WAIT.
REQ-016 Number of bytes per operand or result, N, SHALL be DATA_WIDTH/8.
REQ-017 RX_A: each i_rx_done loads one byte into o_dato_A, LSB byte first; after byte N the FSM goes to RX_B.
REQ-018 RX_B: same rule as RX_A into o_dato_B; after byte N the FSM goes to RX_OP.
REQ-019 RX_OP: one i_rx_done loads i_rx_data[OP_WIDTH-1:0] into o_op, upper bits discarded; next state WAIT_ALU.
REQ-020 Partial operand bytes SHALL be visible on o_dato_A/o_dato_B as they arrive.
REQ-021 WAIT_ALU SHALL last exactly one cycle, then capture i_resultado into an internal result register and go to TX_SEND.
REQ-022 TX_SEND SHALL last one cycle: drive the lowest not-yet-sent result byte on o_tx_data, pulse o_tx_start, and go to TX_WAIT.
REQ-023 TX_WAIT: on i_tx_done go to TX_SEND if bytes remain, else go to RX_A with the byte counter cleared.
REQ-024 Latency: o_tx_start for the first result byte SHALL occur 2 cycles after the i_rx_done cycle that carried the op byte.
REQ-025 i_rx_done in WAIT_ALU, TX_SEND or TX_WAIT SHALL be ignored; the byte is dropped.
REQ-026 i_tx_done outside TX_WAIT SHALL be ignored.
REQ-027 o_dato_A, o_dato_B and o_op SHALL hold their values until overwritten by a new frame.

Reset
REQ-028 While i_rst_n is low, asynchronously: state RX_A, byte counter 0, o_dato_A, o_dato_B, o_op, o_tx_data, result register all 0, o_tx_start 0, o_busy 0.
REQ-029 Reset asserted mid-frame or mid-transmission SHALL abort it; no further o_tx_start until a full new frame is received.

Configuration
REQ-030 Macro ALU_UART_IF_OP_CHECK_EN defined: in RX_OP a code not in {0x20,0x22,0x24,0x25,0x26,0x27,0x02,0x03} SHALL leave o_op unchanged, skip WAIT_ALU, send the single byte 8'hEE via TX_SEND/TX_WAIT, then return to RX_A.
REQ-031 Macro undefined: every op code SHALL be accepted per REQ-019; no error byte is ever sent.

Verification
REQ-032 DATA_WIDTH=8, bytes 0x10, 0x02, 0x20 -> o_op=0x20, one o_tx_start 2 cycles later with o_tx_data=0x12.
REQ-033 DATA_WIDTH=8, bytes 0x90, 0x02, 0x03 (SRA) -> o_tx_data=0xE4; bytes 0x10, 0x02, 0x22 -> o_tx_data=0x0E.
REQ-034 DATA_WIDTH=16, bytes 0x10,0x00, 0x02,0x00, 0x20 -> o_dato_A=0x0010, o_dato_B=0x0002; tx bytes 0x12 then 0x00, the second only after i_tx_done.
REQ-035 i_rx_done with 0x55 pulsed in TX_WAIT -> o_dato_A unchanged; next frame 0x01,0x01,0x20 -> result byte 0x02.
REQ-036 i_rst_n low after the B byte, then frame 0x03,0x04,0x24 -> o_op=0x24, exactly one result 0x00, no stale transmission.
REQ-037 With ALU_UART_IF_OP_CHECK_EN: op byte 0x3F -> o_op unchanged, o_tx_data=0xEE; without the macro the same op byte -> o_op=0x3F and the ALU result is sent.
